// File: rtl/ram_arbiter_if.sv
// Requester-side command/response bundle for ram_arbiter: req/gnt command handshake
// plus the read-return strobe and data.
interface ram_arbiter_if #(
   parameter int unsigned AW = 4,
   parameter int unsigned DW = 8
);
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          gnt;
   logic          rvalid;
   logic [DW-1:0] rdata;

   modport master (
      output req, we, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one registered-read single-port RAM between requesters A and B.
// Winning command is registered onto the RAM bus; read data returns two cycles after grant.
module ram_arbiter #(
   parameter int unsigned AW = 4,
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   ram_arbiter_if.slave  a,
   ram_arbiter_if.slave  b,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   logic last;   // 0 = A won most recently, 1 = B
   logic a_win;
   logic b_win;
   logic acc;
   logic s1_rd;
   logic s1_id;
   logic s2_rd;
   logic s2_id;

   // On a collision the requester that did not win last time gets the slot.
   always_comb begin
      a_win = 1'b0;
      b_win = 1'b0;
      if (!rst) begin
         if (a.req && b.req) begin
            a_win = last;
            b_win = ~last;
         end else begin
            a_win = a.req;
            b_win = b.req;
         end
      end
   end

   assign acc   = a_win | b_win;
   assign a.gnt = a_win;
   assign b.gnt = b_win;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last      <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         s1_rd     <= 1'b0;
         s1_id     <= 1'b0;
         s2_rd     <= 1'b0;
         s2_id     <= 1'b0;
      end else begin
         if (acc) begin
            last      <= b_win;
            ram_we    <= b_win ? b.we : a.we;
            ram_addr  <= b_win ? b.addr : a.addr;
            ram_wdata <= b_win ? b.wdata : a.wdata;
            s1_rd     <= b_win ? ~b.we : ~a.we;
            s1_id     <= b_win;
         end else begin
            // Address/data hold so the RAM bus does not toggle on idle cycles.
            ram_we <= 1'b0;
            s1_rd  <= 1'b0;
         end
         s2_rd <= s1_rd;
         s2_id <= s1_id;
      end
   end

   // ram_rdata is already registered in the RAM, so it lines up with the S2 stage.
   assign a.rvalid = s2_rd & ~s2_id;
   assign b.rvalid = s2_rd & s2_id;
   assign a.rdata  = ram_rdata;
   assign b.rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and random self-checking bench for ram_arbiter with a registered-read RAM model.
module tb_ram_arbiter;
   localparam int unsigned AW = 4;
   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   always #5 clk = ~clk;

   ram_arbiter_if #(.AW(AW), .DW(DW)) a_if ();
   ram_arbiter_if #(.AW(AW), .DW(DW)) b_if ();

   ram_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a_if),
      .b         (b_if),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   // RAM under the arbiter: write and registered read on the same edge.
   logic [7:0] mem [16] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                            8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   // Reference model state.
   logic [7:0] m_mem [16] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                              8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
   logic       m_last  = 1'b0;
   logic       s1_acc  = 1'b0;
   logic       s1_we   = 1'b0;
   logic       s1_rd   = 1'b0;
   logic       s1_id   = 1'b0;
   logic [7:0] s1_data = 8'h00;
   logic       s2_rd   = 1'b0;
   logic       s2_id   = 1'b0;
   logic [7:0] s2_data = 8'h00;

   logic       obs_agnt, obs_bgnt, obs_arv, obs_brv;
   logic [7:0] obs_rdata;
   int         n_err = 0;
   int         n_checks = 0;

   logic       a_pend = 1'b0, b_pend = 1'b0;
   logic       a_we_r, b_we_r;
   logic [3:0] a_ad_r, b_ad_r;
   logic [7:0] a_wd_r, b_wd_r;
   int         a_wait = 0, b_wait = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at the falling edge, check, then advance the model past the next rise.
   task automatic step(input logic r,
                       input logic ar, input logic awe, input logic [3:0] aad, input logic [7:0] awd,
                       input logic br, input logic bwe, input logic [3:0] bad, input logic [7:0] bwd);
      logic       ega, egb, e_arv, e_brv;
      logic [3:0] ad;
      @(negedge clk);
      rst        = r;
      a_if.req   = ar;
      a_if.we    = awe;
      a_if.addr  = aad;
      a_if.wdata = awd;
      b_if.req   = br;
      b_if.we    = bwe;
      b_if.addr  = bad;
      b_if.wdata = bwd;
      #1;
      if (r) begin
         m_last = 1'b0;
         s1_acc = 1'b0;
         s1_we  = 1'b0;
         s1_rd  = 1'b0;
         s2_rd  = 1'b0;
      end
      ega = 1'b0;
      egb = 1'b0;
      if (!r) begin
         if (ar && br) begin
            ega = m_last;
            egb = !m_last;
         end else begin
            ega = ar;
            egb = br;
         end
      end
      e_arv = s2_rd && !s2_id;
      e_brv = s2_rd && s2_id;
      obs_agnt  = a_if.gnt;
      obs_bgnt  = b_if.gnt;
      obs_arv   = a_if.rvalid;
      obs_brv   = b_if.rvalid;
      obs_rdata = a_if.rdata;
      chk("a_gnt", 32'(a_if.gnt), 32'(ega));
      chk("b_gnt", 32'(b_if.gnt), 32'(egb));
      chk("gnt_exclusive", 32'(a_if.gnt & b_if.gnt), 32'd0);
      chk("a_rvalid", 32'(a_if.rvalid), 32'(e_arv));
      chk("b_rvalid", 32'(b_if.rvalid), 32'(e_brv));
      if (e_arv) chk("a_rdata", 32'(a_if.rdata), 32'(s2_data));
      if (e_brv) chk("b_rdata", 32'(b_if.rdata), 32'(s2_data));
      chk("ram_we", 32'(ram_we), 32'(s1_acc && s1_we));
      if (r) begin
         chk("rst_ram_addr", 32'(ram_addr), 32'd0);
         chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
      end
      s2_rd   = s1_rd;
      s2_id   = s1_id;
      s2_data = s1_data;
      if (ega || egb) begin
         ad      = egb ? bad : aad;
         s1_acc  = 1'b1;
         s1_id   = egb;
         s1_we   = egb ? bwe : awe;
         s1_rd   = !s1_we;
         s1_data = m_mem[ad];
         if (s1_we) m_mem[ad] = egb ? bwd : awd;
         m_last  = egb;
      end else begin
         s1_acc = 1'b0;
         s1_we  = 1'b0;
         s1_rd  = 1'b0;
      end
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0);
   endtask

   initial begin
      // Reset held with random requests.
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
         chk("rst_no_gnt", 32'(obs_agnt | obs_bgnt), 32'd0);
      end

      // A writes 0xA5 to addr 3, then reads it back.
      step(1'b0, 1'b1, 1'b1, 4'd3, 8'hA5, 1'b0, 1'b0, 4'd0, 8'd0);
      chk("wr_gnt", 32'(obs_agnt), 32'd1);
      step(1'b0, 1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 4'd0, 8'd0);
      chk("rd_gnt", 32'(obs_agnt), 32'd1);
      chk("wr_pulse", 32'(ram_we), 32'd1);
      idle();
      chk("wr_pulse_end", 32'(ram_we), 32'd0);
      idle();
      chk("rd_rvalid", 32'(obs_arv), 32'd1);
      chk("rd_data", 32'(obs_rdata), 32'hA5);
      chk("rd_b_quiet", 32'(obs_brv), 32'd0);

      // First collision: B, A, B, A; reads return in the same order.
      step(1'b0, 1'b1, 1'b0, 4'd1, 8'd0, 1'b1, 1'b0, 4'd6, 8'd0);
      chk("col0_b", 32'(obs_bgnt), 32'd1);
      step(1'b0, 1'b1, 1'b0, 4'd1, 8'd0, 1'b1, 1'b0, 4'd6, 8'd0);
      chk("col1_a", 32'(obs_agnt), 32'd1);
      step(1'b0, 1'b1, 1'b0, 4'd1, 8'd0, 1'b1, 1'b0, 4'd6, 8'd0);
      chk("col2_b", 32'(obs_bgnt), 32'd1);
      chk("col2_b_rv", 32'(obs_brv), 32'd1);
      chk("col2_data", 32'(obs_rdata), 32'h66);
      step(1'b0, 1'b1, 1'b0, 4'd1, 8'd0, 1'b1, 1'b0, 4'd6, 8'd0);
      chk("col3_a", 32'(obs_agnt), 32'd1);
      chk("col3_a_rv", 32'(obs_arv), 32'd1);
      chk("col3_data", 32'(obs_rdata), 32'h11);
      idle();
      chk("col4_b_rv", 32'(obs_brv), 32'd1);
      idle();
      chk("col5_a_rv", 32'(obs_arv), 32'd1);

      // Reset lands between the read's accept and its RAM sample.
      step(1'b0, 1'b1, 1'b0, 4'd3, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0);
      chk("rr_gnt", 32'(obs_agnt), 32'd1);
      step(1'b1, 1'b1, 1'b0, 4'd7, 8'd0, 1'b1, 1'b1, 4'd8, 8'h5A);
      step(1'b1, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b1, 4'd8, 8'h5A);
      idle();
      chk("rr_no_rv0", 32'(obs_arv), 32'd0);
      idle();
      chk("rr_no_rv1", 32'(obs_arv), 32'd0);
      step(1'b0, 1'b1, 1'b0, 4'd0, 8'd0, 1'b1, 1'b1, 4'd5, 8'h55);
      chk("post_rst_b", 32'(obs_bgnt), 32'd1);
      step(1'b0, 1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0);
      chk("post_rst_a", 32'(obs_agnt), 32'd1);
      step(1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b1, 4'd4, 8'h44);
      chk("set_last_b", 32'(obs_bgnt), 32'd1);

      // A reads addr 9 while B writes 0x3C there, with B last granted.
      step(1'b0, 1'b1, 1'b0, 4'd9, 8'd0, 1'b1, 1'b1, 4'd9, 8'h3C);
      chk("fw_a_first", 32'(obs_agnt), 32'd1);
      step(1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b1, 4'd9, 8'h3C);
      chk("fw_b_next", 32'(obs_bgnt), 32'd1);
      step(1'b0, 1'b1, 1'b0, 4'd9, 8'd0, 1'b0, 1'b0, 4'd0, 8'd0);
      chk("fw_reread_gnt", 32'(obs_agnt), 32'd1);
      chk("fw_old_rv", 32'(obs_arv), 32'd1);
      chk("fw_old_data", 32'(obs_rdata), 32'h99);
      idle();
      idle();
      chk("fw_new_rv", 32'(obs_arv), 32'd1);
      chk("fw_new_data", 32'(obs_rdata), 32'h3C);

      // Random traffic; commands held until granted.
      for (int i = 0; i < 200; i++) begin
         if (!a_pend) begin
            a_pend = ($urandom_range(0, 3) != 0);
            a_we_r = 1'($urandom_range(0, 1));
            a_ad_r = 4'($urandom_range(0, 15));
            a_wd_r = 8'($urandom_range(0, 255));
         end
         if (!b_pend) begin
            b_pend = ($urandom_range(0, 3) != 0);
            b_we_r = 1'($urandom_range(0, 1));
            b_ad_r = 4'($urandom_range(0, 15));
            b_wd_r = 8'($urandom_range(0, 255));
         end
         step(1'b0, a_pend, a_we_r, a_ad_r, a_wd_r, b_pend, b_we_r, b_ad_r, b_wd_r);
         if (a_pend) begin
            if (obs_agnt) begin
               a_pend = 1'b0;
               a_wait = 0;
            end else begin
               a_wait++;
            end
         end
         if (b_pend) begin
            if (obs_bgnt) begin
               b_pend = 1'b0;
               b_wait = 0;
            end else begin
               b_wait++;
            end
         end
         chk("a_wait_max", 32'(a_wait <= 1), 32'd1);
         chk("b_wait_max", 32'(b_wait <= 1), 32'd1);
      end
      idle();
      idle();
      idle();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
